// File: rtl/imm_gen_pipe.sv
// Pipelined immediate extender for the decode stage: decodes Instr[31:7] per ImmSrc,
// registers the result with its tag, and buffers up to two beats behind a valid/ready handshake.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ImmSrc,
  input  logic [24:0]      Instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  ImmExt,
  output logic [TAG_W-1:0] out_tag,
  output logic             illegal
);

  typedef enum logic [1:0] {EMPTY, FULL1, FULL2} state_t;

  typedef struct packed {
    logic             ill;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  imm;
  } beat_t;

  // Re-index the port so field selects read like the ISA manual (bit 31 down to bit 7).
  logic [31:7] ins;
  assign ins = Instr;

  logic signed [11:0] i_imm;
  logic signed [11:0] s_imm;
  logic signed [12:0] b_imm;
  logic signed [20:0] j_imm;
  logic signed [31:0] u_imm;
  logic        [5:0]  shamt;
  logic        [4:0]  zimm;

  assign i_imm = ins[31:20];
  assign s_imm = {ins[31:25], ins[11:7]};
  assign b_imm = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign j_imm = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  assign u_imm = {ins[31:12], 12'b0};
  assign shamt = (XLEN == 64) ? ins[25:20] : {1'b0, ins[24:20]};
  assign zimm  = ins[19:15];

  beat_t dec_next;

  always_comb begin
    dec_next     = '0;
    dec_next.tag = in_tag;
    case (ImmSrc)
      4'b0000: dec_next.imm = XLEN'(i_imm);
      4'b0001: dec_next.imm = XLEN'(s_imm);
      4'b0010: dec_next.imm = XLEN'(b_imm);
      4'b0011: dec_next.imm = XLEN'(j_imm);
      4'b0100: dec_next.imm = XLEN'(shamt);
      4'b0101: dec_next.imm = XLEN'(u_imm);
      4'b0110: dec_next.imm = XLEN'(zimm);
      default: dec_next.ill = 1'b1;
    endcase
  end

  state_t state_reg;
  beat_t  main_reg;
  beat_t  skid_reg;
  logic   out_valid_reg;
  logic   in_ready_reg;

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = in_valid && in_ready_reg;
  assign out_xfer = out_valid_reg && out_ready;

  // in_ready only ever falls when the skid entry fills, so it never depends on out_ready this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= EMPTY;
      main_reg      <= '0;
      skid_reg      <= '0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (in_xfer) begin
            main_reg      <= dec_next;
            out_valid_reg <= 1'b1;
            state_reg     <= FULL1;
          end
        end
        FULL1: begin
          if (out_xfer && in_xfer) begin
            main_reg <= dec_next;
          end else if (out_xfer) begin
            out_valid_reg <= 1'b0;
            state_reg     <= EMPTY;
          end else if (in_xfer) begin
            skid_reg     <= dec_next;
            in_ready_reg <= 1'b0;
            state_reg    <= FULL2;
          end
        end
        FULL2: begin
          if (out_xfer) begin
            main_reg     <= skid_reg;
            in_ready_reg <= 1'b1;
            state_reg    <= FULL1;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          state_reg     <= EMPTY;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign ImmExt    = main_reg.imm;
  assign out_tag   = main_reg.tag;
  assign illegal   = main_reg.ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: drives XLEN=32 and XLEN=64 instances with identical beats and
// compares both against an arithmetic immediate model and an occupancy/FIFO scoreboard.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [3:0]  ImmSrc;
  logic [24:0] Instr;
  logic [31:0] in_tag;
  logic        out_ready;

  logic        r32, v32, ill32;
  logic [31:0] imm32, tag32;
  logic        r64, v64, ill64;
  logic [63:0] imm64;
  logic [31:0] tag64;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r32), .ImmSrc(ImmSrc),
    .Instr(Instr), .in_tag(in_tag), .out_valid(v32), .out_ready(out_ready),
    .ImmExt(imm32), .out_tag(tag32), .illegal(ill32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r64), .ImmSrc(ImmSrc),
    .Instr(Instr), .in_tag(in_tag), .out_valid(v64), .out_ready(out_ready),
    .ImmExt(imm64), .out_tag(tag64), .illegal(ill64)
  );

  typedef struct {
    logic [63:0] i64;
    logic [31:0] i32;
    logic [31:0] tag;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  logic acc;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic longint sx(input longint x, input int n);
    if (x >= (longint'(1) << (n - 1))) return x - (longint'(1) << n);
    return x;
  endfunction

  // Immediate value from the format rules, built with shifts, masks and place values.
  function automatic logic [63:0] ref_imm(input int src, input logic [31:0] w, input int xl);
    longint u;
    longint v;
    logic [63:0] r;
    u = longint'({32'b0, w});
    case (src)
      0: v = sx((u >> 20) & 'hFFF, 12);
      1: v = sx(((u >> 25) & 'h7F) * 32 + ((u >> 7) & 'h1F), 12);
      2: v = sx(((u >> 31) & 1) * 4096 + ((u >> 7) & 1) * 2048
                + ((u >> 25) & 'h3F) * 32 + ((u >> 8) & 'hF) * 2, 13);
      3: v = sx(((u >> 31) & 1) * 1048576 + ((u >> 12) & 'hFF) * 4096
                + ((u >> 20) & 1) * 2048 + ((u >> 21) & 'h3FF) * 2, 21);
      4: v = (u >> 20) & ((xl == 64) ? 63 : 31);
      5: v = sx(u & 'hFFFFF000, 32);
      6: v = (u >> 15) & 31;
      default: v = 0;
    endcase
    r = v;
    if (xl == 32) r[63:32] = '0;
    return r;
  endfunction

  // One clock cycle: drive a beat, check both DUTs against the scoreboard, advance the model.
  task automatic cyc(input logic v, input logic [3:0] src, input logic [31:0] w,
                     input logic [31:0] tag, input logic ordy, output logic accepted);
    exp_t e;
    logic [63:0] t;
    logic in_x, out_x;
    in_valid  = v;
    ImmSrc    = src;
    Instr     = w[31:7];
    in_tag    = tag;
    out_ready = ordy;
    #1;
    chk("in_ready32",  {63'b0, r32}, {63'b0, q.size() < 2});
    chk("in_ready64",  {63'b0, r64}, {63'b0, q.size() < 2});
    chk("out_valid32", {63'b0, v32}, {63'b0, q.size() > 0});
    chk("out_valid64", {63'b0, v64}, {63'b0, q.size() > 0});
    if (q.size() > 0) begin
      chk("imm32",  {32'b0, imm32}, {32'b0, q[0].i32});
      chk("imm64",  imm64, q[0].i64);
      chk("tag32",  {32'b0, tag32}, {32'b0, q[0].tag});
      chk("tag64",  {32'b0, tag64}, {32'b0, q[0].tag});
      chk("ill32",  {63'b0, ill32}, {63'b0, q[0].ill});
      chk("ill64",  {63'b0, ill64}, {63'b0, q[0].ill});
    end
    out_x = (q.size() > 0) && ordy;
    in_x  = v && (q.size() < 2);
    if (out_x) begin
      $display("out tag=%h imm32=%h imm64=%h ill=%b", tag32, imm32, imm64, ill32);
      void'(q.pop_front());
    end
    if (in_x) begin
      e.i64 = ref_imm(int'(src), w, 64);
      t     = ref_imm(int'(src), w, 32);
      e.i32 = t[31:0];
      e.tag = tag;
      e.ill = (src > 4'd6);
      q.push_back(e);
    end
    accepted = in_x;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx;
    logic [31:0] w;
    reset     = 1'b1;
    in_valid  = 1'b0;
    ImmSrc    = '0;
    Instr     = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'b0, v32}, 64'd0);
    chk("rst_in_ready",  {63'b0, r32}, 64'd1);
    chk("rst_imm32",     {32'b0, imm32}, 64'd0);
    chk("rst_imm64",     imm64, 64'd0);
    chk("rst_tag",       {32'b0, tag32}, 64'd0);
    chk("rst_illegal",   {63'b0, ill32}, 64'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed decode cases with hand-computed constants.
    cyc(1'b1, 4'b0000, 32'hFFF00093, 32'h100, 1'b1, acc);
    chk("i_type_valid", {63'b0, v32}, 64'd1);
    chk("i_type_imm",   {32'b0, imm32}, 64'hFFFFFFFF);
    chk("i_type_tag",   {32'b0, tag32}, 64'h100);
    chk("i_type_ill",   {63'b0, ill32}, 64'd0);
    cyc(1'b1, 4'b0010, 32'hFE000EE3, 32'h101, 1'b1, acc);
    chk("b_type_imm",   {32'b0, imm32}, 64'hFFFFFFFC);
    cyc(1'b1, 4'b0100, 32'h03F00000, 32'h102, 1'b1, acc);
    chk("shamt32",      {32'b0, imm32}, 64'h1F);
    chk("shamt64",      imm64, 64'h3F);
    cyc(1'b1, 4'b0101, 32'h80000000, 32'h103, 1'b1, acc);
    chk("u_type64",     imm64, 64'hFFFFFFFF80000000);
    chk("u_type32",     {32'b0, imm32}, 64'h80000000);
    cyc(1'b1, 4'b0111, 32'hFFFFFF80, 32'h104, 1'b1, acc);
    chk("illegal_flag", {63'b0, ill32}, 64'd1);
    chk("illegal_imm",  imm64, 64'd0);
    cyc(1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, acc);

    // Backpressure: tags 1..4 offered continuously, consumer stalls for cycles 2-4.
    idx = 1;
    for (int c = 1; c <= 10; c++) begin
      cyc(idx <= 4, 4'b0000, {20'(idx * 3), 12'h093}, 32'(idx), !(c >= 2 && c <= 4), acc);
      if (acc) idx++;
    end
    chk("bp_all_sent", 64'(idx), 64'd5);

    // Reset while two beats are held.
    cyc(1'b1, 4'b0001, 32'hDEADBEEF, 32'hA, 1'b0, acc);
    cyc(1'b1, 4'b0011, 32'h12345678, 32'hB, 1'b0, acc);
    chk("full2_in_ready", {63'b0, r32}, 64'd0);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    chk("rst_mid_valid32", {63'b0, v32}, 64'd0);
    chk("rst_mid_valid64", {63'b0, v64}, 64'd0);
    q.delete();
    @(negedge clk) reset = 1'b0;
    chk("rst_mid_in_ready", {63'b0, r32}, 64'd1);
    @(posedge clk);
    #1;
    cyc(1'b1, 4'b0011, 32'hCAFEF00D, 32'hC, 1'b1, acc);
    chk("post_rst_latency", {63'b0, v32}, 64'd1);
    chk("post_rst_tag",     {32'b0, tag32}, 64'hC);

    // Randomised traffic.
    for (int n = 0; n < 300; n++) begin
      w = $urandom();
      cyc(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 9)), w, $urandom(),
          1'($urandom_range(0, 2) != 0), acc);
    end

    for (int n = 0; n < 4; n++) cyc(1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, acc);
    chk("drained", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined successor to the combinational immediate extender in the decode stage.
- Takes instruction bits [31:7], an immediate-format select and a sideband tag. Produces an XLEN-wide extended immediate one cycle later.
- Valid/ready handshakes on input and output; a two-entry skid buffer absorbs backpressure with no bubbles.
- Supports RV32/RV64 widths, CSR zimm and illegal-format flagging.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- TAG_W, 32, width of sideband tag (PC, rd index, etc.) carried alongside the immediate.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept an input beat.
- ImmSrc  in  4  immediate format select.
- Instr  in  25  instruction bits [31:7].
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts output beat.
- ImmExt  out  XLEN  extended immediate.
- out_tag  out  TAG_W  tag matching ImmExt.
- illegal  out  1  ImmSrc code was unsupported for this beat.

Behaviour:
- Clocking and reset: one clock domain (clk). reset is asynchronous and active-high.
- Reset values: out_valid=0, in_ready=1, ImmExt=0, out_tag=0, illegal=0, both buffer entries invalid.
- Format decode (S = Instr[31]; sign-extension is always to XLEN):
  - 0000 I-type: sext(Instr[31:20]).
  - 0001 S-type: sext({Instr[31:25],Instr[11:7]}).
  - 0010 B-type: sext({Instr[31],Instr[7],Instr[30:25],Instr[11:8],0}).
  - 0011 J-type: sext({Instr[31],Instr[19:12],Instr[20],Instr[30:21],0}).
  - 0100 shift amount: zero-extended; XLEN=32 uses Instr[24:20], XLEN=64 uses Instr[25:20].
  - 0101 U-type: sext({Instr[31:12],12'b0}). Identical for XLEN=32; upper 32 bits replicate bit 31 for XLEN=64.
  - 0110 CSR zimm: zero-extended Instr[19:15].
  - Any other code: ImmExt=0 and illegal=1 for that beat; the beat still flows through the handshake.
- Handshake rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - ImmExt, out_tag and illegal are held stable while out_valid && !out_ready.
- Latency: exactly 1 cycle from input transfer to out_valid when the buffer is empty. Sustained throughput is 1 beat/cycle while out_ready=1.
- Buffer structure: main output register plus one skid register. in_ready is a registered signal equal to !skid_valid, so there is no combinational path from out_ready to in_ready.
- Buffer state machine:
  - EMPTY: input transfer -> FULL1.
  - FULL1 with output transfer and input transfer: main register reloads -> stay FULL1.
  - FULL1 with output transfer, no input: -> EMPTY.
  - FULL1 with input but no output transfer: beat goes to skid -> FULL2, in_ready falls next cycle.
  - FULL2 with output transfer: skid moves to main, in_ready rises next cycle -> FULL1.
  - FULL2 cannot accept input because in_ready=0.
- Ordering: strict FIFO order; no beat is dropped or duplicated.
- Simultaneous events: an input transfer and an output transfer in the same cycle never lose the output beat.
- Reset asserted mid-operation: out_valid drops immediately (asynchronously), both entries are discarded, and in_ready=1 once reset is released.
- Decode is combinational on input and registered into the buffer; there is no decode logic on the output side.

Test Plan:
- Reset, then Instr[31:7] of 0xFFF00093, ImmSrc=0000, tag=0x100, out_ready=1 -> next cycle out_valid=1, ImmExt=0xFFFFFFFF, out_tag=0x100, illegal=0.
- Instr of 0xFE000EE3 (beq -4), ImmSrc=0010 -> ImmExt=0xFFFFFFFC.
- ImmSrc=0100 with Instr[25:20]=6'h3F:
  - XLEN=32 -> 0x0000001F.
  - XLEN=64 -> 0x000000000000003F.
- ImmSrc=0101 with Instr[31:12]=0x80000, XLEN=64 -> 0xFFFFFFFF80000000.
- ImmSrc=0111 -> illegal=1, ImmExt=0.
- Backpressure: stream tags 1,2,3,4 with in_valid held high; out_ready=0 for cycles 2-4, then 1.
  - in_ready falls the cycle after the second accept.
  - Outputs appear in order 1,2,3,4 with values held stable while stalled.
  - No loss or duplication.
- Assert reset while in FULL2 -> out_valid=0 within the same cycle; after release, in_ready=1 and a new beat emerges with 1-cycle latency.
